// File: rtl/mux2t1_32_pkg.sv
// Shared constants for the word mux block.
package mux2t1_32_pkg;

  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/mux2t1_32_dff_r.sv
// WIDTH-bit register with synchronous active-low reset to RST_VAL.
module dff_r #(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/mux2t1_32.sv
// Two-input word mux: combinational output plus an optional registered copy with valid flag.
module mux2t1_32
  import mux2t1_32_pkg::*;
#(
  parameter int unsigned      WIDTH   = WORD_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] I0,
  input  logic [WIDTH-1:0] I1,
  input  logic             s,
  output logic [WIDTH-1:0] o,
  output logic [WIDTH-1:0] o_q,
  output logic             o_vld
);

  // Continuous ternary keeps bitwise X-merge when s is unknown.
  assign o = s ? I1 : I0;

  dff_r #(
    .WIDTH  (WIDTH),
    .RST_VAL(RST_VAL)
  ) u_q (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (o),
    .q    (o_q)
  );

  dff_r #(
    .WIDTH  (1),
    .RST_VAL(1'b0)
  ) u_vld (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (1'b1),
    .q    (o_vld)
  );

endmodule

// File: tb/tb_mux2t1_32.sv
// Self-checking bench for mux2t1_32: scoreboard of expected registered outputs plus direct combinational checks.
module tb_mux2t1_32;

  typedef struct {
    logic [31:0] q;
    logic        vld;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] I0 = '0;
  logic [31:0] I1 = '0;
  logic        s = 1'b0;
  logic [31:0] o;
  logic [31:0] o_q;
  logic        o_vld;

  int unsigned checks = 0;
  int unsigned failures = 0;
  sb_t         exp_q[$];
  sb_t         prev;
  bit          have_prev = 1'b0;

  always #5 clk = ~clk;

  mux2t1_32 #(
    .WIDTH  (32),
    .RST_VAL(32'h0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .I0   (I0),
    .I1   (I1),
    .s    (s),
    .o    (o),
    .o_q  (o_q),
    .o_vld(o_vld)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle at the falling edge, check o at once, check o_q after the next rising edge.
  task automatic cycle(input string tag, input logic r, input logic sel,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp_o);
    sb_t e;
    @(negedge clk);
    rst_n = r;
    s     = sel;
    I0    = a;
    I1    = b;
    e.q   = r ? exp_o : 32'h0;
    e.vld = r;
    exp_q.push_back(e);
    #1;
    check({tag, "_o"}, o, exp_o);
    if (have_prev) begin
      check({tag, "_qhold"}, o_q, prev.q);
      check({tag, "_vhold"}, {31'b0, o_vld}, {31'b0, prev.vld});
    end
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_empty"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_q"}, o_q, e.q);
      check({tag, "_vld"}, {31'b0, o_vld}, {31'b0, e.vld});
      prev      = e;
      have_prev = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for two edges; o must already be valid.
    cycle("rst0", 1'b0, 1'b0, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0000);
    cycle("rst1", 1'b0, 1'b1, 32'h0000_0000, 32'h0000_00FF, 32'h0000_00FF);

    // Select I0, then change the unselected I1.
    cycle("sel_i0", 1'b1, 1'b0, 32'h0000_0000, 32'h0000_00FF, 32'h0000_0000);
    cycle("i1_ign", 1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000);
    cycle("sel_i1", 1'b1, 1'b1, 32'h0000_0000, 32'h0000_00FF, 32'h0000_00FF);
    cycle("i0_ign", 1'b1, 1'b1, 32'hCAFE_F00D, 32'h0000_00FF, 32'h0000_00FF);

    // Full-width walk, s toggling each 10 ns period.
    for (int i = 0; i < 6; i++) begin
      cycle($sformatf("walk%0d", i), 1'b1, i[0], 32'hA5A5_A5A5, 32'h5A5A_5A5A,
            i[0] ? 32'h5A5A_5A5A : 32'hA5A5_A5A5);
    end

    cycle("edge_k", 1'b1, 1'b1, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF);

    // Mid-stream reset: o_q holds until the edge, o keeps tracking.
    cycle("mid_rst", 1'b0, 1'b0, 32'h1357_9BDF, 32'hFFFF_FFFF, 32'h1357_9BDF);
    cycle("mid_rst2", 1'b0, 1'b1, 32'h1357_9BDF, 32'h2468_ACE0, 32'h2468_ACE0);
    cycle("rel", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFF);
    cycle("boundary", 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000);

    // Unknown select: agreeing bits pass through, differing bits go X.
    @(negedge clk);
    s  = 1'bx;
    I0 = 32'hFFFF_0000;
    I1 = 32'hFFFF_00FF;
    #1;
    check("xsel_hi", {8'h0, o[31:8]}, 32'h00FF_FF00);
    if ($isunknown(s)) check("xsel_lo", {24'h0, o[7:0]}, {24'h0, 8'hxx});
    else               check("xsel_lo2", {24'h0, o[7:0]}, s ? 32'h0000_00FF : 32'h0000_0000);

    check("sb_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
